// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for the UART: decodes the 16-byte register window and
// buffers bytes in RX/TX FIFOs so polling software and back-to-back stores lose nothing.

module uart_mmio_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] STEP_P = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign head  = mem[rptr];
  assign full  = (count == FULL_C);
  assign empty = (count == '0);

  // Callers gate push/pop against full/empty; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + STEP_P;
      end
      if (pop) rptr <= rptr + STEP_P;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_mmio_ctrl #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic        mmio_we,
  input  logic        mmio_re,
  output logic [31:0] mmio_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  localparam logic [31:0] ADDR_STAT = BASE_ADDR;
  localparam logic [31:0] ADDR_RX   = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_TX   = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_ERR  = BASE_ADDR + 32'hC;

  logic sel_stat, sel_rx, sel_tx, sel_err;
  logic do_wr, do_rd;

  logic [7:0]    rx_head, tx_head;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic          rx_push, rx_pop, tx_push, tx_pop;

  logic          rx_underflow, tx_overflow;
  logic          set_unf, set_ovf, clr_unf, clr_ovf;
  logic [31:0]   status_word;
  logic [31:0]   read_word;
  logic          unused_wdata;

  assign unused_wdata = ^mmio_wdata[31:8];

  assign sel_stat = (mmio_addr == ADDR_STAT);
  assign sel_rx   = (mmio_addr == ADDR_RX);
  assign sel_tx   = (mmio_addr == ADDR_TX);
  assign sel_err  = (mmio_addr == ADDR_ERR);

  // A store wins over a load in the same cycle: the load is dropped entirely.
  assign do_wr = mmio_we;
  assign do_rd = mmio_re & ~mmio_we;

  // Both UART links use valid/ready: a byte moves on a rising edge where
  // valid and ready are both high; valid holds its byte stable until then,
  // and ready depends only on FIFO occupancy, never on valid.
  assign uart_rx_ready = rst & ~rx_full;
  assign rx_push       = uart_rx_valid & uart_rx_ready;
  assign rx_pop        = do_rd & sel_rx & ~rx_empty;

  assign uart_tx_valid = ~tx_empty;
  assign uart_tx_data  = tx_head;
  assign tx_pop        = uart_tx_valid & uart_tx_ready;
  // A full TX FIFO still takes a store when the UART drains a byte that same edge.
  assign tx_push       = do_wr & sel_tx & (~tx_full | tx_pop);

  uart_mmio_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (uart_rx_data),
    .head  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  uart_mmio_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (mmio_wdata[7:0]),
    .head  (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign set_unf = do_rd & sel_rx & rx_empty;
  assign set_ovf = do_wr & sel_tx & tx_full & ~tx_pop;
  assign clr_unf = do_wr & sel_err & mmio_wdata[0];
  assign clr_ovf = do_wr & sel_err & mmio_wdata[1];

  // Set beats clear so an error raised during a clear is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_underflow <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      rx_underflow <= set_unf | (rx_underflow & ~clr_unf);
      tx_overflow  <= set_ovf | (tx_overflow & ~clr_ovf);
    end
  end

  assign status_word = {8'h00, 8'(tx_count), 8'(rx_count), 6'b0, ~rx_empty, ~tx_full};

  always_comb begin
    read_word = 32'h0;
    if (sel_stat)     read_word = status_word;
    else if (sel_rx)  read_word = rx_empty ? 32'h0 : {24'h0, rx_head};
    else if (sel_err) read_word = {30'h0, tx_overflow, rx_underflow};
  end

  // Read data is captured from pre-edge state and held until the next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mmio_rdata <= 32'h0;
    end else if (mmio_re) begin
      mmio_rdata <= do_rd ? read_word : 32'h0;
    end
  end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped controller that sequences the on-chip uart for the Riscv151 CPU. It decodes CPU loads/stores to the UART window (0x80000000 status, 0x80000004 RX data, 0x80000008 TX data, 0x8000000C error flags) and buffers bytes in small RX/TX FIFOs. It drives the uart ready/valid handshakes, so software polling and back-to-back stores do not lose bytes.

Parameters:
DEPTH, 8, entries per FIFO (RX and TX each); power of two, 2..128
BASE_ADDR, 32'h80000000, base of the 16-byte register window

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
mmio_addr  in  32  CPU byte address of the access
mmio_wdata  in  32  CPU store data; bits [7:0] used
mmio_we  in  1  store strobe, one cycle per store
mmio_re  in  1  load strobe, one cycle per load
mmio_rdata  out  32  load data, registered, valid the cycle after mmio_re
uart_tx_data  out  8  byte to uart transmitter (TX FIFO head)
uart_tx_valid  out  1  TX FIFO non-empty
uart_tx_ready  in  1  uart transmitter accepts byte
uart_rx_data  in  8  byte from uart receiver
uart_rx_valid  in  1  uart receiver holds a byte
uart_rx_ready  out  1  controller accepts byte (RX FIFO not full)

Behaviour:
- Reset (rst=0, async): both FIFOs empty, pointers/counts 0, error flags 0, mmio_rdata=0, uart_tx_valid=0, uart_rx_ready=0. After release: uart_rx_ready=1 the first edge's combinational view (RX empty).
- Decode: exact match on BASE_ADDR+{0,4,8,C}; any other address -> rdata 0, no side effects.
- Status (+0, read-only): bit0 = TX not full, bit1 = RX not empty, [15:8] = rx_count, [23:16] = tx_count, rest 0. Writes ignored.
- RX data (+4, read): rdata[7:0] = RX head, upper bits 0; pop at the same edge that samples mmio_re. If RX empty: rdata 0, no pop, set rx_underflow flag (bit0 of +C).
- TX data (+8, write): push mmio_wdata[7:0] at the edge. If TX full: byte dropped, set tx_overflow flag (bit1 of +C). Reads of +8 return 0.
- Error flags (+C): read returns {30'b0, tx_overflow, rx_underflow}; write-1-to-clear per bit. A set event and a clear in the same cycle -> flag stays 1.
- Read latency exactly 1 cycle; mmio_rdata holds its value until next mmio_re; status sampled pre-edge (reflects state before any same-cycle pushes/pops).
- mmio_we and mmio_re both high: write executes, read suppressed (rdata=0, no pop).
- RX path: uart_rx_ready = !rx_full (combinational from count). Transfer when uart_rx_valid & uart_rx_ready; when full, byte stays in uart, none lost.
- TX path: uart_tx_valid = !tx_empty, uart_tx_data = TX head (combinational from storage). Pop when valid & ready.
- Simultaneous push+pop on a FIFO: both occur, count unchanged; on full FIFO, push allowed only if pop also occurs same cycle (TX: CPU store while uart pops -> accepted, no overflow); on empty FIFO, pop never returns the same-cycle push (read of empty RX sets underflow even if uart_rx transfer coincides).
- Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1, count in 0..DEPTH.
- Reset mid-operation: all buffered bytes discarded; partially transmitted uart byte is uart's concern, uart_tx_valid drops immediately.

Test Plan:
- Reset then idle: read +0 -> rdata 0x00000001 (TX not full, RX empty); uart_rx_ready=1, uart_tx_valid=0.
- uart_rx delivers 0x7A, read +0 -> 0x00000103; read +4 -> 0x0000007A next cycle; read +0 -> 0x00000001.
- Store 0x61 to +8 with uart_tx_ready=0 -> uart_tx_valid=1, uart_tx_data=0x61, status tx_count=1; raise ready one cycle -> valid drops, count 0.
- With uart_tx_ready=0, 9 stores 0x00..0x08 (DEPTH=8) -> status 0x00080000, +C reads 0x2, uart_tx emits 0x00..0x07 in order; write 0x2 to +C -> reads 0x0.
- Feed 9 RX bytes with no CPU reads -> uart_rx_ready low after 8th, 9th held; 9 reads of +4 return all 9 in order; 10th read returns 0 and sets +C bit0.
- Assert rst=0 asynchronously mid-cycle with 3 bytes in each FIFO -> outputs clear without clock edge; after release status reads 0x00000001.
